// File: rtl/pu_mac.sv
// pu_mac: pipelined CH-wide multiply-accumulate with per-group saturation
module pu_mac #(
  parameter int DATA_W = 5,
  parameter int CH     = 4,
  parameter int BEATS  = 4,
  parameter int OUT_W  = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_last,
  input  logic                   signed_mode,
  input  logic [CH*DATA_W-1:0]   in_data,
  input  logic [CH*DATA_W-1:0]   weight,
  output logic                   out_valid,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_sat,
  output logic                   busy
);
  localparam int ACC_W = 2*DATA_W + $clog2(CH) + $clog2(BEATS) + 1;
  localparam int PW    = 2*DATA_W;
  localparam int CW    = BEATS > 1 ? $clog2(BEATS) : 1;
  logic [CW-1:0]      cnt;
  logic               mode_q, beat_mode, close;
  logic [CH*PW-1:0]   prod, s1_p;
  logic               s1_v, s1_l, s1_m, s2_v, s2_l, s2_m;
  logic [ACC_W-1:0]   sum, s2_sum, acc, tot;
  logic [ACC_W-OUT_W:0] hi;
  logic               ovf;
  logic [OUT_W-1:0]   res;
  assign beat_mode = cnt == '0 ? signed_mode : mode_q;
  assign close     = in_last | (cnt == CW'(BEATS-1));
  assign busy      = (cnt != '0) | s1_v | s2_v;
  for (genvar c = 0; c < CH; c++) begin : g_mul
    logic signed [PW-1:0] a, b;
    assign a = PW'($signed({beat_mode & in_data[c*DATA_W+DATA_W-1], in_data[c*DATA_W +: DATA_W]}));
    assign b = PW'($signed({beat_mode & weight[c*DATA_W+DATA_W-1], weight[c*DATA_W +: DATA_W]}));
    assign prod[c*PW +: PW] = a * b;
  end
  always_comb begin
    sum = '0;
    for (int c = 0; c < CH; c++)
      sum = sum + {{(ACC_W-PW){s1_m & s1_p[c*PW+PW-1]}}, s1_p[c*PW +: PW]};
  end
  always_comb begin
    tot = acc + s2_sum;
    hi  = tot[ACC_W-1:OUT_W-1];
    ovf = s2_m ? ~(&hi | ~|hi) : |hi[ACC_W-OUT_W:1];
    res = ~ovf ? tot[OUT_W-1:0] : s2_m ? {tot[ACC_W-1], {(OUT_W-1){~tot[ACC_W-1]}}} : '1;
  end
  always_ff @(posedge clk) begin
    s1_p   <= prod;
    s1_l   <= close;
    s1_m   <= beat_mode;
    s2_sum <= sum;
    s2_l   <= s1_l;
    s2_m   <= s1_m;
    if (rst) begin
      cnt       <= '0;
      mode_q    <= 1'b0;
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      s1_v      <= in_valid;
      s2_v      <= s1_v;
      out_valid <= s2_v & s2_l;
      if (in_valid) begin
        cnt    <= close ? '0 : cnt + CW'(1);
        mode_q <= beat_mode;
      end
      if (s2_v && s2_l) begin
        acc      <= '0;
        out_data <= res;
        out_sat  <= ovf;
      end else if (s2_v) begin
        acc <= tot;
      end
    end
  end
endmodule

// File: tb/tb_pu_mac.sv
// tb_pu_mac: directed scoreboard bench for pu_mac
module tb_pu_mac;
  localparam int DATA_W = 5, CH = 4, BEATS = 4, OUT_W = 12;
  localparam int SMAX = 2**(OUT_W-1) - 1, SMIN = -(2**(OUT_W-1)), UMAX = 2**OUT_W - 1;
  typedef struct {
    logic [OUT_W-1:0] data;
    logic             sat;
    int               at;
  } exp_t;
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, signed_mode = 0;
  logic [CH*DATA_W-1:0] in_data = '0, weight = '0;
  logic out_valid, out_sat, busy;
  logic [OUT_W-1:0] out_data;
  int checks = 0, errors = 0, cyc = 0;
  exp_t q[$];
  int m_cnt = 0, m_acc = 0;
  logic m_mode = 0;
  logic [CH*DATA_W-1:0] u = {5'd4, 5'd3, 5'd2, 5'd1}, one = {4{5'd1}}, m16 = {4{5'b10000}};
  pu_mac #(.DATA_W(DATA_W), .CH(CH), .BEATS(BEATS), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .signed_mode(signed_mode),
    .in_data(in_data), .weight(weight), .out_valid(out_valid), .out_data(out_data),
    .out_sat(out_sat), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int val(input logic [DATA_W-1:0] x, input logic s);
    logic signed [DATA_W-1:0] sx;
    sx = x;
    return s ? int'(sx) : int'(x);
  endfunction
  task automatic beat(input logic [CH*DATA_W-1:0] d, input logic [CH*DATA_W-1:0] w,
                      input logic last, input logic sm);
    exp_t e;
    int s;
    @(negedge clk);
    in_valid = 1; in_last = last; signed_mode = sm; in_data = d; weight = w;
    if (m_cnt == 0) m_mode = sm;
    s = 0;
    for (int c = 0; c < CH; c++)
      s += val(d[c*DATA_W +: DATA_W], m_mode) * val(w[c*DATA_W +: DATA_W], m_mode);
    m_acc += s;
    if (last || m_cnt == BEATS-1) begin
      e.sat  = m_mode ? (m_acc > SMAX || m_acc < SMIN) : (m_acc > UMAX);
      e.data = OUT_W'(m_mode ? (m_acc > SMAX ? SMAX : m_acc < SMIN ? SMIN : m_acc)
                             : (m_acc > UMAX ? UMAX : m_acc));
      e.at   = cyc + 3;
      q.push_back(e);
      m_cnt = 0; m_acc = 0;
    end else m_cnt++;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 0; in_last = 1; signed_mode = ~signed_mode;
      in_data = CH*DATA_W'($urandom); weight = CH*DATA_W'($urandom);
    end
  endtask
  task automatic drain();
    for (int i = 0; i < 12 && q.size() != 0; i++) idle(1);
    idle(2);
    check("drain_empty", q.size(), 0);
    check("drain_busy", busy, 0);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (q.size() == 0) check("spurious_pulse", out_valid, 0);
      else begin
        e = q.pop_front();
        check("out_data", out_data, e.data);
        check("out_sat", out_sat, e.sat);
        check("pulse_cycle", cyc, e.at);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_busy", busy, 0);
    rst = 0;
    beat(u, one, 0, 0);
    @(posedge clk); #1;
    check("busy_open", busy, 1);
    repeat (3) beat(u, one, 0, 0);
    drain();
    check("basic_hold", out_data, 40);
    beat(u, one, 0, 0);
    beat(u, one, 1, 0);
    repeat (4) beat(u, one, 0, 0);
    drain();
    check("early_hold", out_data, 40);
    repeat (4) beat('1, '1, 0, 0);
    drain();
    check("usat_hold", out_data, 4095);
    check("usat_flag", out_sat, 1);
    beat(m16, m16, 0, 1);
    repeat (3) beat(m16, m16, 0, 0);
    drain();
    check("ssat_hold", out_data, 2047);
    check("ssat_flag", out_sat, 1);
    beat({4{5'h1f}}, {4{5'd3}}, 1, 1);
    drain();
    check("neg_hold", out_data, 12'hff4);
    check("neg_flag", out_sat, 0);
    repeat (2) beat(one, one, 0, 0);
    idle(3);
    repeat (2) beat(one, one, 0, 0);
    drain();
    check("gap_hold", out_data, 16);
    repeat (2) beat(u, one, 0, 0);
    @(negedge clk);
    rst = 1; in_valid = 0; in_last = 0;
    m_cnt = 0; m_acc = 0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    rst = 0;
    repeat (4) beat(u, one, 0, 0);
    drain();
    check("fresh_hold", out_data, 40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pu_mac.md
# pu_mac

Parametrised multiply-accumulate processing unit: the next generation of our fixed 4-input processing unit. Each accepted beat multiplies CH input/weight pairs. A registered adder tree sums the products, and the sums of several beats are accumulated into one group result. The result is saturated to OUT_W bits and delivered with a one-cycle valid pulse. The block sits between the input/weight buffers and the activation stage of the datapath.

## Interface
- DATA_W, 5, width of each input and weight element
- CH, 4, channels per beat; power of two, ≥2
- BEATS, 4, maximum beats per group; ≥1
- OUT_W, 12, result width; must be < ACC_W
- Derived: ACC_W = 2*DATA_W + clog2(CH) + clog2(BEATS) + 1
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  beat present this cycle
- in_last  in  1  closes the current group on this beat; qualified by in_valid
- signed_mode  in  1  1 = two's-complement operands and result, 0 = unsigned; sampled on the first beat of a group
- in_data  in  CH*DATA_W  input vector; channel c at [c*DATA_W +: DATA_W]
- weight  in  CH*DATA_W  weight vector; same packing as in_data
- out_valid  out  1  one-cycle pulse: out_data and out_sat are valid
- out_data  out  OUT_W  saturated group result
- out_sat  out  1  saturation occurred for this result
- busy  out  1  group open or beats in flight

## Operation
- Pipeline, with each stage carrying its own valid, last and mode bits:
  - S1: CH products of 2*DATA_W bits each, registered.
  - S2: registered adder tree sum, sign- or zero-extended to ACC_W per the group mode.
  - S3: accumulator, output register and control.
- Mode latch: signed_mode is captured on the first beat after reset or after a group close. Changes on later beats of the same group are ignored.
- Beat counter, 0..BEATS-1: increments on every accepted beat. A group closes when in_last=1 or when the counter reaches BEATS-1. On close the counter returns to 0.
- Accumulation at S3 for a non-closing beat: acc <= acc + sum.
- S3 on a closing beat:
  - out_data <= sat(acc + sum)
  - out_sat <= (saturation occurred)
  - out_valid <= 1
  - acc <= 0
- The next group may start on the very next cycle; no bubble is required between groups.
- Saturation range:
  - Signed: [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Unsigned: [0, 2^OUT_W-1].
- Gaps in in_valid are allowed inside a group. Pipeline stages without a valid beat do not change acc.
- busy = (counter≠0) | S1 valid | S2 valid.
- Reset values: out_valid=0, out_data=0, out_sat=0, busy=0, acc=0, counter=0, all stage valids=0.
- Reset mid-group discards the partial group and all in-flight beats. No out_valid is produced for them.
- in_last=1 with in_valid=0 is ignored.

## Timing
- A beat sampled at edge E0 is in S1 after E0 and in S2 after E1. It updates acc/out at E2.
- out_valid is high in the cycle after E2, exactly one cycle. Latency is 3 edges from the closing beat.
- Throughput: one beat per cycle, no stalls. No output backpressure: the consumer must take the result in the out_valid cycle.
- out_data and out_sat hold their value until the next out_valid.

## Test plan
- Unsigned basic:
  - Stimulus: 4 beats back-to-back, in_data={4,3,2,1}, weight={1,1,1,1}.
  - Response: out_data=40 and out_sat=0, with out_valid on the cycle after the 4th beat's E2.
- Early close:
  - Stimulus: same vectors, in_last on beat 2, then 4 more beats immediately.
  - Response: out_data=20, then out_data=40. Pulses occur 4 cycles apart.
- Unsigned saturation:
  - Stimulus: all elements 31 × 31, 4 beats.
  - Response: out_data=4095 and out_sat=1 (the true sum is 15376).
- Signed saturation and mode latch:
  - Stimulus: signed_mode=1 on beat 1 then 0 on beats 2–4; all elements -16 × -16.
  - Response: the group stays signed, out_data=2047 and out_sat=1 (the true sum is 4096).
  - Stimulus: signed, inputs -1 × weights 3, 1 beat with in_last.
  - Response: out_data=-12 (0xFF4) and out_sat=0.
- Gaps and reset:
  - Stimulus: 2 beats, 3 idle cycles, 2 beats of {1,1,1,1}×{1,1,1,1}.
  - Response: out_data=16.
  - Stimulus: 2 beats, assert rst for 1 cycle, then a fresh 4-beat group.
  - Response: no pulse from the aborted group, busy=0 after reset, and the next result equals the fresh group alone.
